// File: rtl/buffer_dma_pkg.sv
// buffer_dma_pkg: shared types and limits for the buffer DMA controller.
// Optional feature macro used by the slice: BUFFER_DMA_PROGRESS_EN.
package buffer_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_RUN,
    LD_DRAIN,
    SV_RD,
    SV_WAIT,
    SV_REQ,
    DONE
  } state_e;

  localparam int MAX_OUT_LIMIT = 15;
  localparam int OUT_W         = 4;
  localparam int BUF_W         = 16;

endpackage

// File: rtl/dma_addr_gen.sv
// dma_addr_gen: per-direction memory address, buffer pointer and
// word counters with lookahead done compares.
module dma_addr_gen
  import buffer_dma_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] words,
  input  logic [BUF_W-1:0]  buf_start,
  input  logic              mem_adv,
  input  logic              buf_adv,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BUF_W-1:0]  buf_addr,
  output logic [ADDR_W-1:0] count,
  output logic              issue_done,
  output logic              issue_last,
  output logic              rcvd_last
);

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BUF_W-1:0]  buf_addr_q, buf_addr_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic [ADDR_W-1:0] issued_q, issued_d;
  logic [ADDR_W-1:0] rcvd_q, rcvd_d;

  always_comb begin
    mem_addr_d = mem_addr_q;
    buf_addr_d = buf_addr_q;
    words_d    = words_q;
    issued_d   = issued_q;
    rcvd_d     = rcvd_q;
    if (load) begin
      mem_addr_d = start_addr;
      buf_addr_d = buf_start;
      words_d    = words;
      issued_d   = '0;
      rcvd_d     = '0;
    end else begin
      if (mem_adv) begin
        mem_addr_d = mem_addr_q + ADDR_W'(1);
        issued_d   = issued_q + ADDR_W'(1);
      end
      if (buf_adv) begin
        buf_addr_d = buf_addr_q + BUF_W'(1);
        rcvd_d     = rcvd_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q <= '0;
      buf_addr_q <= '0;
      words_q    <= '0;
      issued_q   <= '0;
      rcvd_q     <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      buf_addr_q <= buf_addr_d;
      words_q    <= words_d;
      issued_q   <= issued_d;
      rcvd_q     <= rcvd_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign buf_addr   = buf_addr_q;
  assign count      = rcvd_q;
  assign issue_done = (issued_q == words_q);
  assign issue_last = ((issued_q + ADDR_W'(1)) == words_q);
  assign rcvd_last  = ((rcvd_q + ADDR_W'(1)) == words_q);

endmodule

// File: rtl/buffer_dma_ctrl.sv
// buffer_dma_ctrl: moves words between external memory and the on-chip
// buffer. Define BUFFER_DMA_PROGRESS_EN to add the progress_words port.
module buffer_dma_ctrl
  import buffer_dma_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              start_save,
  input  logic              abort,
  input  logic [ADDR_W-1:0] ld_start,
  input  logic [ADDR_W-1:0] ld_words,
  input  logic [ADDR_W-1:0] sv_start,
  input  logic [ADDR_W-1:0] sv_words,
  input  logic [BUF_W-1:0]  ld_buf_addr,
  input  logic [BUF_W-1:0]  sv_buf_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic              buf_wr_en,
  output logic              buf_rd_en,
  output logic [BUF_W-1:0]  buf_addr,
  output logic [15:0]       buf_wdata,
  input  logic [15:0]       buf_rdata,
  output logic              busy,
  output logic              buffer_loaded,
  output logic              buffer_saved
`ifdef BUFFER_DMA_PROGRESS_EN
  ,
  output logic [ADDR_W-1:0] progress_words
`endif
);

  localparam int MAX_CLAMP =
    (MAX_OUTSTANDING > MAX_OUT_LIMIT) ? MAX_OUT_LIMIT :
    (MAX_OUTSTANDING < 1) ? 1 : MAX_OUTSTANDING;
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_CLAMP);

  state_e state_q, state_d;

  logic [OUT_W-1:0] out_q, out_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             dir_q, dir_d;
  logic             ld_flag_q, ld_flag_d;
  logic             sv_flag_q, sv_flag_d;

  logic              ld_load, sv_load;
  logic              ld_grant, ld_rx, ld_store, sv_grant;
  logic [ADDR_W-1:0] ld_mem_addr, sv_mem_addr;
  logic [BUF_W-1:0]  ld_buf_ptr, sv_buf_ptr;
  logic [ADDR_W-1:0] ld_cnt, sv_cnt;
  logic              ld_issue_done, ld_issue_last, ld_rcvd_last;
  logic              sv_issue_done, sv_issue_last, sv_rcvd_last;
  logic              unused_ok;

  assign ld_load  = (state_q == IDLE) && start_load;
  assign sv_load  = (state_q == IDLE) && start_save && !start_load;
  assign ld_grant = mem_req && mem_gnt && !mem_we;
  // Returns only count against requests issued since the last reset.
  assign ld_rx    = mem_rvalid && (out_q != '0) &&
                    ((state_q == LD_RUN) || (state_q == LD_DRAIN));
  assign ld_store = ld_rx && (state_q == LD_RUN) && !abort;
  assign sv_grant = (state_q == SV_REQ) && !abort && mem_gnt;

  dma_addr_gen #(.ADDR_W(ADDR_W)) u_ld_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (ld_load),
    .start_addr (ld_start),
    .words      (ld_words),
    .buf_start  (ld_buf_addr),
    .mem_adv    (ld_grant),
    .buf_adv    (ld_store),
    .mem_addr   (ld_mem_addr),
    .buf_addr   (ld_buf_ptr),
    .count      (ld_cnt),
    .issue_done (ld_issue_done),
    .issue_last (ld_issue_last),
    .rcvd_last  (ld_rcvd_last)
  );

  dma_addr_gen #(.ADDR_W(ADDR_W)) u_sv_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (sv_load),
    .start_addr (sv_start),
    .words      (sv_words),
    .buf_start  (sv_buf_addr),
    .mem_adv    (sv_grant),
    .buf_adv    (sv_grant),
    .mem_addr   (sv_mem_addr),
    .buf_addr   (sv_buf_ptr),
    .count      (sv_cnt),
    .issue_done (sv_issue_done),
    .issue_last (sv_issue_last),
    .rcvd_last  (sv_rcvd_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_load)
          state_d = (ld_words == '0) ? DONE : LD_RUN;
        else if (start_save)
          state_d = (sv_words == '0) ? DONE : SV_RD;
      end
      LD_RUN: begin
        if (abort)
          state_d = LD_DRAIN;
        else if (ld_store && ld_rcvd_last)
          state_d = DONE;
      end
      LD_DRAIN: if (out_q == '0) state_d = IDLE;
      SV_RD:    state_d = abort ? IDLE : SV_WAIT;
      SV_WAIT:  state_d = abort ? IDLE : SV_REQ;
      SV_REQ: begin
        if (abort)
          state_d = IDLE;
        else if (mem_gnt)
          state_d = sv_issue_last ? DONE : SV_RD;
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    buf_wr_en = 1'b0;
    buf_rd_en = 1'b0;
    buf_addr  = '0;
    buf_wdata = '0;
    unique case (state_q)
      LD_RUN: begin
        mem_req   = !abort && !ld_issue_done && (out_q < MAX_OUT);
        mem_addr  = ld_mem_addr;
        buf_wr_en = ld_store;
        buf_addr  = ld_buf_ptr;
        buf_wdata = ld_store ? mem_rdata : 16'h0;
      end
      SV_RD: begin
        buf_rd_en = 1'b1;
        buf_addr  = sv_buf_ptr;
      end
      SV_REQ: begin
        mem_req   = !abort;
        mem_we    = !abort;
        mem_addr  = sv_mem_addr;
        mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign buffer_loaded = ld_flag_q;
  assign buffer_saved  = sv_flag_q;

  always_comb begin
    out_d = out_q;
    if (ld_grant && !ld_rx)
      out_d = out_q + OUT_W'(1);
    else if (!ld_grant && ld_rx)
      out_d = out_q - OUT_W'(1);
    wdata_d = (state_q == SV_WAIT) ? buf_rdata : wdata_q;
    dir_d = dir_q;
    if (ld_load)      dir_d = 1'b0;
    else if (sv_load) dir_d = 1'b1;
    ld_flag_d = ld_flag_q;
    sv_flag_d = sv_flag_q;
    if (ld_load) ld_flag_d = 1'b0;
    if (sv_load) sv_flag_d = 1'b0;
    // Flag rises on entry to DONE so it is visible during DONE.
    if ((state_d == DONE) && (state_q != DONE)) begin
      if (dir_d) sv_flag_d = 1'b1;
      else       ld_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      wdata_q   <= '0;
      dir_q     <= 1'b0;
      ld_flag_q <= 1'b0;
      sv_flag_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      wdata_q   <= wdata_d;
      dir_q     <= dir_d;
      ld_flag_q <= ld_flag_d;
      sv_flag_q <= sv_flag_d;
    end
  end

`ifdef BUFFER_DMA_PROGRESS_EN
  assign progress_words = dir_q ? sv_cnt : ld_cnt;
  assign unused_ok = ^{ld_issue_last, sv_issue_done, sv_rcvd_last};
`else
  assign unused_ok = ^{ld_issue_last, sv_issue_done, sv_rcvd_last,
                       ld_cnt, sv_cnt};
`endif

endmodule

// File: doc/buffer_dma_ctrl.md
BUFFER_DMA_CTRL -- requirements
Module: buffer_dma_ctrl

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, is the maximum number of in-flight external-memory reads (range 1..15).
REQ-002 Parameter ADDR_W, default 32, is the external-memory word-address width.
REQ-003 Port clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Ports start_load, start_save, abort, input, 1 each: single-cycle command pulses from the register file's write-one-to-clear (WOC) strobes.
REQ-006 Ports ld_start, ld_words, input, ADDR_W each: load start address and word count ({upper,lower} register pair).
REQ-007 Ports sv_start, sv_words, input, ADDR_W each: save start address and word count.
REQ-008 Ports ld_buf_addr, sv_buf_addr, input, 16 each: first on-chip buffer address for load and for save.
REQ-009 Ports mem_req, mem_we, output, 1 each; mem_addr, output, ADDR_W; mem_wdata, output, 16; mem_gnt, input, 1: external-memory request channel.
REQ-010 Ports mem_rvalid, input, 1; mem_rdata, input, 16: in-order read-return channel.
REQ-011 Ports buf_wr_en, output, 1; buf_rd_en, output, 1; buf_addr, output, 16; buf_wdata, output, 16; buf_rdata, input, 16: buffer port with 1-cycle read latency.
REQ-012 Ports busy, buffer_loaded, buffer_saved, output, 1 each: status outputs for the status register.

Function
REQ-013 FSM states SHALL be IDLE, LD_RUN, LD_DRAIN, SV_RD, SV_WAIT, SV_REQ and DONE.
REQ-014 IDLE: start_load SHALL latch the load parameters and go to LD_RUN; start_save SHALL latch the save parameters and go to SV_RD; if both pulse in the same cycle, load SHALL win and save SHALL be dropped.
REQ-015 A start pulse in any state other than IDLE SHALL be ignored.
REQ-016 Accepting a start SHALL clear the matching flag (buffer_loaded or buffer_saved).
REQ-017 A word count of 0 SHALL go directly to DONE and set the flag with no memory or buffer traffic.
REQ-018 LD_RUN: mem_req=1 and mem_we=0 SHALL be asserted while issued<words and outstanding<MAX_OUTSTANDING.
REQ-019 LD_RUN: mem_addr SHALL advance by 1 on each cycle where mem_req&&mem_gnt.
REQ-020 mem_req and mem_addr SHALL stay stable until mem_gnt.
REQ-021 Each mem_rvalid SHALL produce buf_wr_en=1 in the same cycle, with buf_wdata=mem_rdata and buf_addr=current pointer; the pointer SHALL then increment.
REQ-022 The outstanding counter SHALL handle grant and rvalid in the same cycle as net zero.
REQ-023 When received==words the FSM SHALL go to DONE.
REQ-024 Save: SV_RD SHALL pulse buf_rd_en for 1 cycle; SV_WAIT SHALL capture buf_rdata; SV_REQ SHALL hold mem_req=1, mem_we=1, mem_wdata until mem_gnt.
REQ-025 After each save grant, the FSM SHALL go to SV_RD if words remain, otherwise to DONE.
REQ-026 DONE SHALL last 1 cycle, set the flag and return to IDLE.
REQ-027 Flags SHALL be sticky until the next matching start or rst.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 abort in a load state SHALL stop issue immediately and go to LD_DRAIN.
REQ-030 LD_DRAIN SHALL discard returns (no buf_wr_en) until outstanding==0, then go to IDLE with buffer_loaded left at 0.
REQ-031 abort in a save state SHALL go to IDLE immediately; a request already asserted SHALL be dropped.
REQ-032 mem_addr SHALL wrap modulo 2^ADDR_W; buf_addr SHALL wrap modulo 2^16.
REQ-033 Counters SHALL be ADDR_W bits; the outstanding counter SHALL be 4 bits.

Reset
REQ-034 rst SHALL force IDLE and clear all counters and pointers, including mid-transfer.
REQ-035 Reset value of every output SHALL be 0.
REQ-036 Read returns for requests issued before rst SHALL be the memory side's responsibility and SHALL be ignored.

Configuration
REQ-037 With BUFFER_DMA_PROGRESS_EN defined, output progress_words[ADDR_W-1:0] SHALL exist and SHALL report the words completed in the current or last transfer (cleared on start).
REQ-038 Without BUFFER_DMA_PROGRESS_EN, the port and its counter SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-039 Package buffer_dma_pkg SHALL hold the state enum typedef and the MAX_OUTSTANDING upper-bound constant.
REQ-040 Sub-module dma_addr_gen SHALL implement the address/count generator (load, increment, done compare) and SHALL be instantiated once per direction.

Verification
REQ-041 Load, ld_start=0x100, ld_words=3, ld_buf_addr=0x10, gnt always 1, rvalid 2 cycles later -> mem_addr 0x100..0x102; buf writes at 0x10..0x12; buffer_loaded=1; busy=0 after.
REQ-042 Save, sv_words=2, sv_buf_addr=0x20, buf_rdata=0xAAAA/0x5555, gnt delayed 3 cycles -> two writes 0xAAAA@sv_start, 0x5555@sv_start+1 held until gnt; buffer_saved=1.
REQ-043 ld_words=8, MAX_OUTSTANDING=4, rvalid withheld -> exactly 4 grants, then mem_req=0 until the first rvalid.
REQ-044 abort after 2 grants of a 6-word load -> no further requests; 2 returns discarded; IDLE; buffer_loaded=0.
REQ-045 start_load and start_save in the same cycle with ld_words=0 -> load path only; buffer_loaded=1 next cycle; no save traffic.
REQ-046 ld_start=0xFFFF_FFFF, ld_buf_addr=0xFFFF, 2 words -> mem_addr 0xFFFF_FFFF then 0x0; buf_addr 0xFFFF then 0x0000.
